agu_ntt_param: RTL and testbench

- Parametrised address generation unit for in-place radix-2 NTT/INTT over N = 2^LOG_N coefficients.
- Emits one butterfly pair per accepted cycle: memory address (MA) and bank (BN) for both operands, twiddle index, stage number.
- Successor to the fixed-size k2 AGU. Adds configurable size and stage count, forward/inverse ordering, valid/ready backpressure, abort, and twiddle indexing.
- Sits between the NTT controller (start/mode) and the two-bank coefficient memory plus BFU.

---
 rtl/agu_ntt_pkg.sv | 29 ++
 rtl/agu_order_xlate.sv | 70 +++++++
 rtl/agu_ntt_param.sv | 130 +++++++++++++
 tb/tb_agu_ntt_param.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/agu_ntt_pkg.sv
// Shared types and index helpers for the parametrised NTT address generation unit.
package agu_ntt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    // Widest coefficient index supported (LOG_N up to 12).
    localparam int unsigned IDX_MAX_W = 12;

    function automatic logic [IDX_MAX_W-1:0] insert_zero_bit(
        input logic [IDX_MAX_W-1:0] j,
        input int unsigned          p
    );
        logic [IDX_MAX_W-1:0] low_mask;
        low_mask = (IDX_MAX_W'(1) << p) - IDX_MAX_W'(1);
        return ((j & ~low_mask) << 1) | (j & low_mask);
    endfunction

    function automatic logic xor_reduce_bank(input logic [IDX_MAX_W-1:0] idx);
        return ^idx;
    endfunction

endpackage

// File: rtl/agu_order_xlate.sv
// Output stage: translates (stage, j, mode) into bank/address/twiddle and holds it
// under valid/ready backpressure.
module agu_order_xlate
    import agu_ntt_pkg::*;
#(
    parameter int unsigned LOG_N = 8,
    parameter int unsigned MA_W  = LOG_N - 1,
    parameter int unsigned ST_W  = $clog2(LOG_N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ST_W-1:0]  in_stage,
    input  logic [MA_W-1:0]  in_j,
    input  logic             in_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [MA_W-1:0]  ma0,
    output logic [MA_W-1:0]  ma1,
    output logic             bn0,
    output logic             bn1,
    output logic [LOG_N-1:0] tw_idx,
    output logic [ST_W-1:0]  stage,
    output logic             last
);

    int unsigned          p;
    logic [IDX_MAX_W-1:0] idx0;
    logic [IDX_MAX_W-1:0] idx1;
    logic [LOG_N-1:0]     tw_next;

    always_comb begin
        p       = (mode == MODE_INV) ? 32'(in_stage) : LOG_N - 1 - 32'(in_stage);
        idx0    = insert_zero_bit(IDX_MAX_W'(in_j), p);
        idx1    = idx0 | (IDX_MAX_W'(1) << p);
        tw_next = (LOG_N'(1) << (LOG_N - 1 - p)) + (LOG_N'(in_j) >> p);
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ma0       <= '0;
            ma1       <= '0;
            bn0       <= 1'b0;
            bn1       <= 1'b0;
            tw_idx    <= '0;
            stage     <= '0;
            last      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                ma0    <= idx0[LOG_N-1:1];
                ma1    <= idx1[LOG_N-1:1];
                bn0    <= xor_reduce_bank(idx0);
                bn1    <= xor_reduce_bank(idx1);
                tw_idx <= tw_next;
                stage  <= in_stage;
                last   <= in_last;
            end
        end
    end

endmodule

// File: rtl/agu_ntt_param.sv
// Radix-2 in-place NTT/INTT address generator: run FSM, (stage, j) counters and
// pipeline stage A feeding the translation stage.
module agu_ntt_param
    import agu_ntt_pkg::*;
#(
    parameter int unsigned LOG_N     = 8,
    parameter int unsigned NUM_STAGE = LOG_N,
    parameter int unsigned MA_W      = LOG_N - 1,
    parameter int unsigned ST_W      = $clog2(LOG_N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [MA_W-1:0]  ma0,
    output logic [MA_W-1:0]  ma1,
    output logic             bn0,
    output logic             bn1,
    output logic [LOG_N-1:0] tw_idx,
    output logic [ST_W-1:0]  stage,
    output logic             last,
    output logic             done,
    output logic             busy
);

    state_t          state;
    logic            mode_q;
    logic [MA_W-1:0] j_cnt;
    logic [ST_W-1:0] s_cnt;
    logic            a_valid;
    logic [ST_W-1:0] a_stage;
    logic [MA_W-1:0] a_j;
    logic            a_last;
    logic            x_ready;
    logic            a_ready;
    logic            final_pair;

    assign a_ready    = !a_valid || x_ready;
    assign final_pair = (j_cnt == '1) && (s_cnt == ST_W'(NUM_STAGE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode_q  <= MODE_FWD;
            j_cnt   <= '0;
            s_cnt   <= '0;
            a_valid <= 1'b0;
            a_stage <= '0;
            a_j     <= '0;
            a_last  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state   <= IDLE;
                a_valid <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            mode_q <= mode;
                            j_cnt  <= '0;
                            s_cnt  <= '0;
                            busy   <= 1'b1;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        // j wraps and s steps on the same load, so stages run back to back.
                        if (a_ready) begin
                            a_valid <= 1'b1;
                            a_stage <= s_cnt;
                            a_j     <= j_cnt;
                            a_last  <= final_pair;
                            j_cnt   <= j_cnt + MA_W'(1);
                            if (j_cnt == '1) begin
                                s_cnt <= s_cnt + ST_W'(1);
                            end
                            if (final_pair) begin
                                state <= DRAIN;
                            end
                        end
                    end
                    DRAIN: begin
                        if (a_ready) begin
                            a_valid <= 1'b0;
                        end
                        if (out_valid && out_ready && last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    agu_order_xlate #(
        .LOG_N (LOG_N),
        .MA_W  (MA_W),
        .ST_W  (ST_W)
    ) u_xlate (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .mode      (mode_q),
        .in_valid  (a_valid),
        .in_ready  (x_ready),
        .in_stage  (a_stage),
        .in_j      (a_j),
        .in_last   (a_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .ma0       (ma0),
        .ma1       (ma1),
        .bn0       (bn0),
        .bn1       (bn1),
        .tw_idx    (tw_idx),
        .stage     (stage),
        .last      (last)
    );

endmodule

// File: tb/tb_agu_ntt_param.sv
// Scoreboard bench for agu_ntt_param: an 8-point/3-stage instance and a 16-point/1-stage instance.
module tb_agu_ntt_param;

    typedef struct {
        int ma0;
        int ma1;
        int bn0;
        int bn1;
        int tw;
        int st;
        int last;
    } pair_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start3, mode3, abort3, rdy3, vld3, bn0_3, bn1_3, last3, done3, busy3;
    logic [1:0] ma0_3, ma1_3, st3;
    logic [2:0] tw3;
    logic [11:0] bus3;

    logic       start4, mode4, abort4, rdy4, vld4, bn0_4, bn1_4, last4, done4, busy4;
    logic [2:0] ma0_4, ma1_4;
    logic [1:0] st4;
    logic [3:0] tw4;

    int errors = 0;
    int checks = 0;

    pair_t sb3[$];
    pair_t sb4[$];
    pair_t obs3[16];
    int hs3 = 0, hs4 = 0, done3_cnt = 0, done4_cnt = 0;
    bit stall_prev3 = 1'b0, done_due3 = 1'b0, done_due4 = 1'b0;
    logic [11:0] held3;

    assign bus3 = {ma0_3, ma1_3, bn0_3, bn1_3, tw3, st3, last3};

    agu_ntt_param #(.LOG_N(3), .NUM_STAGE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .abort(abort3),
        .out_ready(rdy3), .out_valid(vld3), .ma0(ma0_3), .ma1(ma1_3), .bn0(bn0_3),
        .bn1(bn1_3), .tw_idx(tw3), .stage(st3), .last(last3), .done(done3), .busy(busy3)
    );

    agu_ntt_param #(.LOG_N(4), .NUM_STAGE(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .abort(abort4),
        .out_ready(rdy4), .out_valid(vld4), .ma0(ma0_4), .ma1(ma1_4), .bn0(bn0_4),
        .bn1(bn1_4), .tw_idx(tw4), .stage(st4), .last(last4), .done(done4), .busy(busy4)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // idx0 is the j-th index (ascending) whose bit p is clear.
    function automatic pair_t model(input int ln, input int ns, input bit md, input int k);
        pair_t r;
        int half, s, j, p, cnt, i0, i1;
        half = 1 << (ln - 1);
        s    = k / half;
        j    = k % half;
        p    = md ? s : ln - 1 - s;
        cnt  = 0;
        i0   = 0;
        for (int i = 0; i < (1 << ln); i++) begin
            if (((i >> p) & 1) == 0) begin
                if (cnt == j) i0 = i;
                cnt++;
            end
        end
        i1     = i0 + (1 << p);
        r.ma0  = i0 >> 1;
        r.ma1  = i1 >> 1;
        r.bn0  = $countones(i0) & 1;
        r.bn1  = $countones(i1) & 1;
        r.tw   = (1 << (ln - 1 - p)) + (j >> p);
        r.st   = s;
        r.last = (k == ns * half - 1) ? 1 : 0;
        return r;
    endfunction

    task automatic cmp_pair(input pair_t g, input pair_t e);
        check("ma0", g.ma0, e.ma0);
        check("ma1", g.ma1, e.ma1);
        check("bn0", g.bn0, e.bn0);
        check("bn1", g.bn1, e.bn1);
        check("tw_idx", g.tw, e.tw);
        check("stage", g.st, e.st);
        check("last", g.last, e.last);
        check("bank_diff", int'(g.bn0 != g.bn1), 1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev3 = 1'b0;
            done_due3   = 1'b0;
        end else begin : mon3
            pair_t g;
            if (stall_prev3) begin
                check("hold_valid", int'(vld3), 1);
                check("hold_outputs", int'(bus3), int'(held3));
            end
            if (done_due3) begin
                check("done_pulse", int'(done3), 1);
                check("busy_at_done", int'(busy3), 0);
                done_due3 = 1'b0;
            end else begin
                check("done_unexpected", int'(done3), 0);
            end
            if (done3) done3_cnt++;
            if (vld3 && rdy3 && !abort3) begin
                g = '{int'(ma0_3), int'(ma1_3), int'(bn0_3), int'(bn1_3), int'(tw3), int'(st3), int'(last3)};
                if (sb3.size() == 0) check("sb3_pending", sb3.size(), 1);
                else cmp_pair(g, sb3.pop_front());
                if (hs3 < 16) obs3[hs3] = g;
                hs3++;
                if (last3) done_due3 = 1'b1;
            end
            stall_prev3 = vld3 && !rdy3 && !abort3;
            held3       = bus3;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            done_due4 = 1'b0;
        end else begin : mon4
            pair_t g;
            if (done_due4) begin
                check("done4_pulse", int'(done4), 1);
                done_due4 = 1'b0;
            end else begin
                check("done4_unexpected", int'(done4), 0);
            end
            if (done4) done4_cnt++;
            if (vld4 && rdy4 && !abort4) begin
                g = '{int'(ma0_4), int'(ma1_4), int'(bn0_4), int'(bn1_4), int'(tw4), int'(st4), int'(last4)};
                if (sb4.size() == 0) check("sb4_pending", sb4.size(), 1);
                else cmp_pair(g, sb4.pop_front());
                hs4++;
                if (last4) done_due4 = 1'b1;
            end
        end
    end

    task automatic start3_run(input bit md);
        for (int k = 0; k < 12; k++) sb3.push_back(model(3, 3, md, k));
        hs3 = 0;
        @(posedge clk); #1;
        start3 = 1'b1;
        mode3  = md;
        @(posedge clk); #1;
        start3 = 1'b0;
        mode3  = !md;
        check("busy_after_start", int'(busy3), 1);
        check("latency_e0", int'(vld3), 0);
        @(posedge clk); #1;
        check("latency_e1", int'(vld3), 0);
        @(posedge clk); #1;
        check("latency_e2", int'(vld3), 1);
    endtask

    task automatic wait_done3(input bit stall);
        int d0, n;
        d0 = done3_cnt;
        n  = 0;
        while (done3_cnt == d0 && n < 300) begin
            @(posedge clk); #1;
            if (stall) rdy3 = 1'($urandom_range(0, 1));
            n++;
        end
        rdy3 = 1'b1;
        check("run3_finished", int'(done3_cnt != d0), 1);
        check("run3_pairs", hs3, 12);
        check("sb3_drained", sb3.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst_n  = 1'b0;
        start3 = 1'b0; mode3 = 1'b0; abort3 = 1'b0; rdy3 = 1'b1;
        start4 = 1'b0; mode4 = 1'b0; abort4 = 1'b0; rdy4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs3", int'({vld3, busy3, done3, bus3}), 0);
        check("reset_outputs4", int'({vld4, busy4, done4, ma0_4, ma1_4, bn0_4, bn1_4, tw4, st4, last4}), 0);
        rst_n = 1'b1;

        start3_run(1'b0);
        wait_done3(1'b0);
        check("fwd_p0_ma0", obs3[0].ma0, 0);
        check("fwd_p0_ma1", obs3[0].ma1, 2);
        check("fwd_p0_bn0", obs3[0].bn0, 0);
        check("fwd_p0_bn1", obs3[0].bn1, 1);
        check("fwd_p0_tw", obs3[0].tw, 1);
        check("fwd_p3_ma0", obs3[3].ma0, 1);
        check("fwd_p3_ma1", obs3[3].ma1, 3);
        check("fwd_p3_tw", obs3[3].tw, 1);
        check("fwd_s2j1_ma0", obs3[9].ma0, 1);
        check("fwd_s2j1_ma1", obs3[9].ma1, 1);
        check("fwd_s2j1_bn0", obs3[9].bn0, 1);
        check("fwd_s2j1_tw", obs3[9].tw, 5);
        check("fwd_p11_last", obs3[11].last, 1);

        start3_run(1'b1);
        wait_done3(1'b0);
        check("inv_s0j2_ma0", obs3[2].ma0, 2);
        check("inv_s0j2_ma1", obs3[2].ma1, 2);
        check("inv_s0j2_bn0", obs3[2].bn0, 1);
        check("inv_s0j2_bn1", obs3[2].bn1, 0);
        check("inv_s0j2_tw", obs3[2].tw, 6);

        start3_run(1'b0);
        wait_done3(1'b1);

        start3_run(1'b0);
        for (int n = 0; n < 50 && hs3 < 5; n++) begin
            @(posedge clk); #1;
        end
        check("abort_point", hs3, 5);
        abort3 = 1'b1;
        @(posedge clk); #1;
        abort3 = 1'b0;
        check("abort_valid", int'(vld3), 0);
        check("abort_busy", int'(busy3), 0);
        check("abort_done", int'(done3), 0);
        sb3.delete();
        d = done3_cnt;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done_later", done3_cnt, d);

        start3 = 1'b1;
        abort3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        abort3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("start_abort_idle_busy", int'(busy3), 0);
        check("start_abort_idle_valid", int'(vld3), 0);

        start3_run(1'b0);
        wait_done3(1'b0);

        start3_run(1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({vld3, busy3, done3, bus3}), 0);
        #1;
        rst_n = 1'b1;
        sb3.delete();
        @(posedge clk); #1;
        check("post_reset_valid", int'(vld3), 0);
        check("post_reset_busy", int'(busy3), 0);
        start3_run(1'b0);
        wait_done3(1'b0);

        for (int k = 0; k < 8; k++) sb4.push_back(model(4, 1, 1'b0, k));
        hs4 = 0;
        d   = done4_cnt;
        @(posedge clk); #1;
        start4 = 1'b1;
        mode4  = 1'b0;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start4 = 1'b1;
        mode4  = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int n = 0; n < 100 && done4_cnt == d; n++) begin
            @(posedge clk); #1;
        end
        check("run4_finished", int'(done4_cnt != d), 1);
        check("run4_pairs", hs4, 8);
        check("sb4_drained", sb4.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        check("run4_no_restart_busy", int'(busy4), 0);
        check("run4_no_restart_valid", int'(vld4), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
